// File: rtl/uart_rx_module.sv
// uart_rx_module
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
//
// Register map (word accesses only):
//   BASE_ADDR + 0 : DATA   read  -> {24'h0, FIFO head} (0 when empty), pops one entry
//                          write -> ignored
//   BASE_ADDR + 4 : STATUS read  -> {24'h0, count[3:0], frame_err, overrun, full, not_empty}
//                          write -> bit 2 clears overrun, bit 3 clears frame_err (W1C)
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   per_en, per_haddr,
//   per_hwrite, per_htrans address phase of the peripheral bus
//   per_hsize, per_hburst,
//   per_hmastlock         accepted but unused
//   per_hwdata            write data (data phase)
//   per_hrdata            read data (data phase), 0 when not selected
//   uart_rx               asynchronous serial input, idle high
//   rx_irq                high while the receive FIFO holds data
module uart_rx_module #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0100,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        per_en,
    input  logic [31:0] per_haddr,
    input  logic        per_hwrite,
    input  logic [2:0]  per_hsize,
    input  logic [2:0]  per_hburst,
    input  logic        per_hmastlock,
    input  logic [1:0]  per_htrans,
    input  logic [31:0] per_hwdata,
    output logic [31:0] per_hrdata,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;

    logic            rxSync1_q, rxSync2_q, rxPrev_q;
    rxState_t        state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            pushReq, frameErrSet;

    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overrun_q, overrun_d, frameErr_q, frameErr_d;
    logic            sel_q, sel_d, selAddr2_q, selAddr2_d, selWrite_q, selWrite_d;

    logic            fifoEmpty, fifoFull, popDo, pushDo, statusWr;
    logic [3:0]      countNibble;
    logic            unusedInputs;

    // Inputs that the register map has no use for are folded together so
    // they are visibly consumed.
    assign unusedInputs = ^{per_hsize, per_hburst, per_hmastlock, per_htrans[0],
                            per_haddr[1:0], per_hwdata[31:4], per_hwdata[1:0]};

    assign fifoEmpty   = (count_q == '0);
    assign fifoFull    = (count_q == CW'(FIFO_DEPTH));
    assign countNibble = 4'(count_q);
    assign rx_irq      = !fifoEmpty;

    // Receiver FSM next state. START waits half a bit so every later sample
    // lands in the middle of its bit; DATA shifts LSB-first.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        pushReq     = 1'b0;
        frameErrSet = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxPrev_q && !rxSync2_q) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (timer_q == HALF_END) begin
                    timer_d  = '0;
                    bitIdx_d = '0;
                    state_d  = rxSync2_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    shift_d = {rxSync2_q, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rxSync2_q) begin
                        pushReq = 1'b1;
                    end else begin
                        frameErrSet = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus decode, FIFO bookkeeping and sticky flags. A pop frees a slot in
    // the same cycle, so a push into a full FIFO still succeeds alongside it.
    // Hardware sets are applied after W1C clears so the set wins.
    always_comb begin
        sel_d      = per_en && per_htrans[1] && (per_haddr[31:3] == BASE_ADDR[31:3]);
        selAddr2_d = per_haddr[2];
        selWrite_d = per_hwrite;

        popDo    = sel_q && !selWrite_q && !selAddr2_q && !fifoEmpty;
        pushDo   = pushReq && (!fifoFull || popDo);
        statusWr = sel_q && selWrite_q && selAddr2_q;

        rdPtr_d = popDo  ? rdPtr_q + PW'(1) : rdPtr_q;
        wrPtr_d = pushDo ? wrPtr_q + PW'(1) : wrPtr_q;
        count_d = count_q;
        if (pushDo && !popDo) begin
            count_d = count_q + CW'(1);
        end else if (popDo && !pushDo) begin
            count_d = count_q - CW'(1);
        end

        overrun_d = overrun_q;
        if (statusWr && per_hwdata[2]) overrun_d = 1'b0;
        if (pushReq && !pushDo) overrun_d = 1'b1;

        frameErr_d = frameErr_q;
        if (statusWr && per_hwdata[3]) frameErr_d = 1'b0;
        if (frameErrSet) frameErr_d = 1'b1;
    end

    // Read data for the data phase of a selected read.
    always_comb begin
        per_hrdata = '0;
        if (sel_q && !selWrite_q) begin
            if (selAddr2_q) begin
                per_hrdata = {24'h0, countNibble, frameErr_q, overrun_q, fifoFull, !fifoEmpty};
            end else if (!fifoEmpty) begin
                per_hrdata = {24'h0, fifoMem[rdPtr_q]};
            end
        end
    end

    // Control state. The synchronizer resets to the idle line level so a
    // reset never manufactures a false start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1_q  <= 1'b1;
            rxSync2_q  <= 1'b1;
            rxPrev_q   <= 1'b1;
            state_q    <= IDLE;
            timer_q    <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
            sel_q      <= 1'b0;
            selAddr2_q <= 1'b0;
            selWrite_q <= 1'b0;
        end else begin
            rxSync1_q  <= uart_rx;
            rxSync2_q  <= rxSync1_q;
            rxPrev_q   <= rxSync2_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
            sel_q      <= sel_d;
            selAddr2_q <= selAddr2_d;
            selWrite_q <= selWrite_d;
        end
    end

    // FIFO storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!reset && pushDo) begin
            fifoMem[wrPtr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module
// Directed bench for uart_rx_module with CLKS_PER_BIT=16 and a 4-entry FIFO.
// A table of single-frame cases is followed by hand-written sequences for
// overrun, glitch rejection, simultaneous push/pop and reset mid-frame.
module tb_uart_rx_module;

    localparam int          CLKS        = 16;
    localparam logic [31:0] DATA_ADDR   = 32'h8000_0100;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0104;

    logic        clk;
    logic        reset;
    logic        per_en;
    logic [31:0] per_haddr;
    logic        per_hwrite;
    logic [2:0]  per_hsize;
    logic [2:0]  per_hburst;
    logic        per_hmastlock;
    logic [1:0]  per_htrans;
    logic [31:0] per_hwdata;
    logic [31:0] per_hrdata;
    logic        uart_rx;
    logic        rx_irq;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rd;
    logic [31:0] coincideRead;

    typedef struct {
        logic [7:0]  frameByte;
        logic        stopBit;
        logic [31:0] expStatus;
        logic [31:0] expData;
        logic [31:0] clearMask;
        logic [31:0] expPost;
    } vec_t;

    vec_t vectors [5];

    uart_rx_module #(
        .CLKS_PER_BIT(CLKS),
        .BASE_ADDR   (DATA_ADDR),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .per_en       (per_en),
        .per_haddr    (per_haddr),
        .per_hwrite   (per_hwrite),
        .per_hsize    (per_hsize),
        .per_hburst   (per_hburst),
        .per_hmastlock(per_hmastlock),
        .per_htrans   (per_htrans),
        .per_hwdata   (per_hwdata),
        .per_hrdata   (per_hrdata),
        .uart_rx      (uart_rx),
        .rx_irq       (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus transfer: address phase on one cycle, data phase on the next.
    task automatic busAccess(input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata, input logic [1:0] trans,
                             output logic [31:0] rdata);
        @(negedge clk);
        per_en     = 1'b1;
        per_haddr  = addr;
        per_hwrite = write;
        per_htrans = trans;
        @(negedge clk);
        per_en     = 1'b0;
        per_haddr  = '0;
        per_hwrite = 1'b0;
        per_htrans = 2'b00;
        per_hwdata = wdata;
        rdata      = per_hrdata;
        @(posedge clk);
        #1 per_hwdata = '0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] rdata);
        busAccess(addr, 1'b0, 32'h0, 2'b10, rdata);
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        busAccess(addr, 1'b1, wdata, 2'b10, dummy);
    endtask

    // Serial frame: start, 8 data bits LSB-first, stop, then one idle bit time.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        uart_rx = stopBit;
        repeat (CLKS) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CLKS) @(negedge clk);
    endtask

    initial begin
        vectors[0] = '{8'h55, 1'b1, 32'h11, 32'h55, 32'h0, 32'h0};
        vectors[1] = '{8'hA3, 1'b0, 32'h08, 32'h00, 32'h8, 32'h0};
        vectors[2] = '{8'h00, 1'b1, 32'h11, 32'h00, 32'h0, 32'h0};
        vectors[3] = '{8'hFF, 1'b1, 32'h11, 32'hFF, 32'h0, 32'h0};
        vectors[4] = '{8'h81, 1'b1, 32'h11, 32'h81, 32'h0, 32'h0};

        reset         = 1'b1;
        per_en        = 1'b0;
        per_haddr     = '0;
        per_hwrite    = 1'b0;
        per_hsize     = 3'b010;
        per_hburst    = 3'b000;
        per_hmastlock = 1'b0;
        per_htrans    = 2'b00;
        per_hwdata    = '0;
        uart_rx       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset hrdata", per_hrdata, 32'h0);
        checkOutput("reset irq", {31'h0, rx_irq}, 32'h0);
        readReg(STATUS_ADDR, rd);
        checkOutput("reset status", rd, 32'h0);

        // Single-frame table
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vectors[v].frameByte, vectors[v].stopBit);
            checkOutput($sformatf("vec%0d irq", v), {31'h0, rx_irq},
                        {31'h0, vectors[v].expStatus[0]});
            readReg(STATUS_ADDR, rd);
            checkOutput($sformatf("vec%0d status", v), rd, vectors[v].expStatus);
            readReg(DATA_ADDR, rd);
            checkOutput($sformatf("vec%0d data", v), rd, vectors[v].expData);
            if (vectors[v].clearMask != 32'h0) writeReg(STATUS_ADDR, vectors[v].clearMask);
            readReg(STATUS_ADDR, rd);
            checkOutput($sformatf("vec%0d post status", v), rd, vectors[v].expPost);
            checkOutput($sformatf("vec%0d post irq", v), {31'h0, rx_irq}, 32'h0);
        end

        // Address decode: wrong word and idle transfer type return 0 and do not pop
        applyStimulus(8'h66, 1'b1);
        readReg(DATA_ADDR + 32'h8, rd);
        checkOutput("decode miss", rd, 32'h0);
        busAccess(DATA_ADDR, 1'b0, 32'h0, 2'b01, rd);
        checkOutput("idle htrans", rd, 32'h0);
        readReg(STATUS_ADDR, rd);
        checkOutput("decode status", rd, 32'h11);
        readReg(DATA_ADDR, rd);
        checkOutput("decode data", rd, 32'h66);

        // Overrun: fifth frame dropped
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
        readReg(STATUS_ADDR, rd);
        checkOutput("overrun status", rd, 32'h47);
        for (int i = 1; i <= 4; i++) begin
            readReg(DATA_ADDR, rd);
            checkOutput($sformatf("overrun data%0d", i), rd, 32'(i));
        end
        readReg(STATUS_ADDR, rd);
        checkOutput("overrun drained", rd, 32'h04);
        writeReg(DATA_ADDR, 32'hC);
        readReg(STATUS_ADDR, rd);
        checkOutput("data write ignored", rd, 32'h04);
        writeReg(STATUS_ADDR, 32'h4);
        readReg(STATUS_ADDR, rd);
        checkOutput("overrun cleared", rd, 32'h0);

        // Glitch of 4 clocks is rejected, then a real frame still works
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        readReg(STATUS_ADDR, rd);
        checkOutput("glitch status", rd, 32'h0);
        checkOutput("glitch irq", {31'h0, rx_irq}, 32'h0);
        applyStimulus(8'h5A, 1'b1);
        readReg(DATA_ADDR, rd);
        checkOutput("after glitch data", rd, 32'h5A);

        // Full FIFO: pop in the same cycle as the stop-bit push
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
        readReg(STATUS_ADDR, rd);
        checkOutput("prefill status", rd, 32'h43);
        fork
            applyStimulus(8'h14, 1'b1);
            begin
                repeat (153) @(negedge clk);
                readReg(DATA_ADDR, coincideRead);
            end
        join
        checkOutput("coincide pop data", coincideRead, 32'h10);
        readReg(STATUS_ADDR, rd);
        checkOutput("coincide status", rd, 32'h43);
        for (int i = 1; i <= 4; i++) begin
            readReg(DATA_ADDR, rd);
            checkOutput($sformatf("coincide data%0d", i), rd, 32'h10 + 32'(i));
        end
        readReg(STATUS_ADDR, rd);
        checkOutput("coincide drained", rd, 32'h0);

        // Reset during bit 3 abandons the frame
        fork
            applyStimulus(8'hF8, 1'b1);
            begin
                repeat (71) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        readReg(STATUS_ADDR, rd);
        checkOutput("mid-frame reset status", rd, 32'h0);
        applyStimulus(8'h3C, 1'b1);
        readReg(STATUS_ADDR, rd);
        checkOutput("post-reset status", rd, 32'h11);
        readReg(DATA_ADDR, rd);
        checkOutput("post-reset data", rd, 32'h3C);
        readReg(STATUS_ADDR, rd);
        checkOutput("post-reset drained", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_module.md
UART_RX_MODULE -- requirements
Module: uart_rx_module

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning system clocks per UART bit (25 MHz / 115200 baud).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0100, meaning the byte address of the DATA register; STATUS is at BASE_ADDR+4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning receive FIFO entries.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 per_en  input  1  peripheral-space enable from the core.
REQ-007 per_haddr  input  32  bus address.
REQ-008 per_hwrite  input  1  1 = write transfer.
REQ-009 per_hsize  input  3  transfer size; ignored, all accesses are treated as word accesses.
REQ-010 per_hburst  input  3  ignored.
REQ-011 per_hmastlock  input  1  ignored.
REQ-012 per_htrans  input  2  transfer type; a transfer is valid when bit 1 is set.
REQ-013 per_hwdata  input  32  write data, data phase.
REQ-014 per_hrdata  output  32  read data, data phase; 0 when not selected.
REQ-015 uart_rx  input  1  asynchronous serial line, idle high, 8N1.
REQ-016 rx_irq  output  1  high while the FIFO is non-empty.

Function
REQ-017 uart_rx SHALL pass through a 2-flop synchronizer; all receive logic SHALL use only the synchronized value.
REQ-018 Address phase: when per_en=1, per_htrans[1]=1 and per_haddr[31:3]==BASE_ADDR[31:3], the block SHALL register sel=1, per_haddr[2] and per_hwrite; otherwise it SHALL register sel=0.
REQ-019 Data phase (next cycle): per_hrdata SHALL be driven combinationally from the registered select: DATA = {24'h0, FIFO head}, or 0 when the FIFO is empty; STATUS = {24'h0, count[3:0], frame_err, overrun, full, not_empty}.
REQ-020 A DATA read in the data phase SHALL pop one entry at the end of that cycle; a pop when the FIFO is empty SHALL have no effect.
REQ-021 A STATUS write in the data phase SHALL clear overrun if per_hwdata[2]=1 and frame_err if per_hwdata[3]=1 (write-1-to-clear); DATA writes and other bits SHALL be ignored.
REQ-022 Receiver FSM states SHALL be IDLE, START, DATA, STOP, with a bit-timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-023 IDLE->START on a synchronized 1->0 transition; the timer clears.
REQ-024 START: at timer = CLKS_PER_BIT/2-1 (integer division), sample the line; low -> DATA with the timer cleared; high -> IDLE (glitch, nothing recorded).
REQ-025 DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register LSB-first; after bit 7 -> STOP.
REQ-026 STOP: after CLKS_PER_BIT cycles, sample; high -> push the byte; low -> set frame_err and discard the byte; in both cases -> IDLE.
REQ-027 A push with the FIFO full SHALL discard the new byte and set overrun; the FIFO contents SHALL be unchanged.
REQ-028 A push and a pop in the same cycle SHALL both take effect with count unchanged; when full, the pop takes effect first, so the push succeeds and overrun is not set.
REQ-029 The FIFO SHALL be a circular buffer with wrap-around read/write pointers; count SHALL range 0..FIFO_DEPTH.
REQ-030 A hardware set of a sticky flag SHALL win over a simultaneous W1C clear.
REQ-031 A byte pushed in cycle N SHALL be readable and rx_irq=1 from cycle N+1.

Reset
REQ-032 On reset the block SHALL: set the FSM to IDLE; clear the timer, bit index and shift register; empty the FIFO (pointers and count = 0); clear overrun, frame_err and sel; preset both synchronizer flops to 1.
REQ-033 After reset, outputs SHALL be per_hrdata=0 and rx_irq=0; reset asserted mid-frame SHALL abandon the frame with no push and no flag set.

Verification (bench uses CLKS_PER_BIT=16)
REQ-034 Drive frame 0x55 -> rx_irq=1; STATUS read = 32'h0000_0011; DATA read = 32'h55; then STATUS = 0 and rx_irq=0.
REQ-035 Drive 5 frames 0x01..0x05 without reads -> STATUS = 32'h0000_0047 (count 4, overrun, full, not_empty); reads return 0x01..0x04; write 32'h4 to STATUS -> overrun clears.
REQ-036 Drive frame 0xA3 with stop bit low -> STATUS = 32'h0000_0008, FIFO empty; write 32'h8 -> STATUS = 0.
REQ-037 Drive a 4-clock low glitch on uart_rx -> FSM returns to IDLE; STATUS remains 0.
REQ-038 With the FIFO full, a DATA pop coincides with a stop-bit push -> count stays 4, overrun=0, and the new byte is the last entry read.
REQ-039 Assert reset during bit 3 of a frame, then send 0x3C -> only 0x3C is received; STATUS = 32'h0000_0011.
